// File: rtl/jtpinpon_objline.sv
// jtpinpon_objline: sprite row draw engine with a 2x256 pixel double line buffer.
// A draw request fetches one 16-pixel 2bpp row, maps it through the colour PROM
// and writes opaque pixels into the draw half. The other half is shown and erased.
module jtpinpon_objline #(
    parameter logic [7:0] HOFFSET = 8'd6
) (
    input  logic        rst,
    input  logic        clk,
    input  logic        pxl_cen,
    input  logic        cen2,
    input  logic        LHBL,
    input  logic        hinit_x,
    input  logic [8:0]  hdump,
    input  logic        draw,
    output logic        busy,
    input  logic [7:0]  code,
    input  logic [7:0]  xpos,
    input  logic [4:0]  pal,
    input  logic        hflip,
    input  logic        vflip,
    input  logic [3:0]  ysub,
    input  logic [3:0]  prog_data,
    input  logic [7:0]  prog_addr,
    input  logic        prog_en,
    output logic        rom_cs,
    output logic [11:0] rom_addr,
    input  logic [31:0] rom_data,
    input  logic        rom_ok,
    output logic [3:0]  pxl
);

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_SETTLE = 2'd1,
        ST_FETCH  = 2'd2,
        ST_DRAW   = 2'd3
    } state_t;

    state_t       state_q, state_d;
    logic         busy_q, busy_d;
    logic         rom_cs_q, rom_cs_d;
    logic [11:0]  rom_addr_q, rom_addr_d;
    logic [31:0]  data_q, data_d;
    logic [4:0]   pal_q, pal_d;
    logic         hflip_q, hflip_d;
    logic [7:0]   xpos_q, xpos_d;
    logic [4:0]   cnt_q, cnt_d;
    logic         hinit_last_q, hinit_last_d;
    logic         bank_q, bank_d;
    logic         hold_blank_q, hold_blank_d;
    logic         wr_en_q, wr_en_d;
    logic [7:0]   wr_col_q, wr_col_d;
    logic [3:0]   pxl_q, pxl_d;

    // Memories: colour PROM with a registered read port, and the two line halves
    logic [3:0]   prom_mem [0:255];
    logic [3:0]   prom_dout;
    logic [3:0]   lbuf [0:511];

    logic         hinit_rise_s;
    logic [3:0]   sel_s;
    logic [4:0]   hi_idx_s;
    logic [4:0]   lo_idx_s;
    logic [1:0]   pix_s;
    logic [7:0]   prom_raddr_s;
    logic         lbuf_we_s;
    logic [7:0]   rd_col_s;
    logic [8:0]   rd_addr_s;
    logic [3:0]   rd_val_s;
    logic         unused_s;

    assign unused_s = hdump[8];

    // Line-start edge detect, pixel select for the current draw column, buffer addressing
    always_comb begin
        hinit_rise_s = cen2 & hinit_x & ~hinit_last_q;
        sel_s        = hflip_q ? ~cnt_q[3:0] : cnt_q[3:0];
        hi_idx_s     = 5'd31 - {1'b0, sel_s};
        lo_idx_s     = 5'd15 - {1'b0, sel_s};
        pix_s        = {data_q[hi_idx_s], data_q[lo_idx_s]};
        prom_raddr_s = {1'b0, pal_q, pix_s};
        // A write still in flight when the line swaps is dropped with the draw
        lbuf_we_s    = wr_en_q & ~hinit_rise_s & (prom_dout != 4'd0);
        rd_col_s     = hdump[7:0] + HOFFSET;
        rd_addr_s    = {~bank_q, rd_col_s};
        rd_val_s     = lbuf[rd_addr_s];
    end

    // Draw FSM: accept request, fetch the row, step through 16 pixels; line start aborts
    always_comb begin
        state_d    = state_q;
        busy_d     = busy_q;
        rom_cs_d   = rom_cs_q;
        rom_addr_d = rom_addr_q;
        data_d     = data_q;
        pal_d      = pal_q;
        hflip_d    = hflip_q;
        xpos_d     = xpos_q;
        cnt_d      = cnt_q;
        if (hinit_rise_s) begin
            state_d  = ST_IDLE;
            busy_d   = 1'b0;
            rom_cs_d = 1'b0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (cen2 && draw) begin
                        state_d    = ST_SETTLE;
                        busy_d     = 1'b1;
                        rom_cs_d   = 1'b1;
                        rom_addr_d = {code, vflip ? ~ysub : ysub};
                        pal_d      = pal;
                        hflip_d    = hflip;
                        xpos_d     = xpos;
                    end else begin
                        state_d = ST_IDLE;
                    end
                end
                ST_SETTLE: begin
                    // rom_ok may still reflect the previous request here
                    state_d = ST_FETCH;
                end
                ST_FETCH: begin
                    if (rom_ok) begin
                        data_d   = rom_data;
                        rom_cs_d = 1'b0;
                        cnt_d    = 5'd0;
                        state_d  = ST_DRAW;
                    end else begin
                        state_d = ST_FETCH;
                    end
                end
                ST_DRAW: begin
                    // Count 16 lands the last pipelined write, then release the scanner
                    if (cnt_q == 5'd16) begin
                        state_d = ST_IDLE;
                        busy_d  = 1'b0;
                    end else begin
                        cnt_d = cnt_q + 5'd1;
                    end
                end
                default: begin
                    state_d  = ST_IDLE;
                    busy_d   = 1'b0;
                    rom_cs_d = 1'b0;
                end
            endcase
        end
    end

    // Bank swap, write pipeline and pixel output
    always_comb begin
        hinit_last_d = cen2 ? hinit_x : hinit_last_q;
        bank_d       = hinit_rise_s ? ~bank_q : bank_q;
        hold_blank_d = hinit_rise_s ? 1'b0 : hold_blank_q;
        wr_en_d      = ~hinit_rise_s && (state_q == ST_DRAW) && (cnt_q < 5'd16);
        wr_col_d     = xpos_q + {4'd0, cnt_q[3:0]};
        if (pxl_cen) begin
            if (hold_blank_q || !LHBL) begin
                pxl_d = 4'd0;
            end else begin
                pxl_d = rd_val_s;
            end
        end else begin
            pxl_d = pxl_q;
        end
    end

    // State registers with asynchronous reset
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= ST_IDLE;
            busy_q       <= 1'b0;
            rom_cs_q     <= 1'b0;
            rom_addr_q   <= 12'd0;
            data_q       <= 32'd0;
            pal_q        <= 5'd0;
            hflip_q      <= 1'b0;
            xpos_q       <= 8'd0;
            cnt_q        <= 5'd0;
            hinit_last_q <= 1'b0;
            bank_q       <= 1'b0;
            hold_blank_q <= 1'b1;
            wr_en_q      <= 1'b0;
            wr_col_q     <= 8'd0;
            pxl_q        <= 4'd0;
        end else begin
            state_q      <= state_d;
            busy_q       <= busy_d;
            rom_cs_q     <= rom_cs_d;
            rom_addr_q   <= rom_addr_d;
            data_q       <= data_d;
            pal_q        <= pal_d;
            hflip_q      <= hflip_d;
            xpos_q       <= xpos_d;
            cnt_q        <= cnt_d;
            hinit_last_q <= hinit_last_d;
            bank_q       <= bank_d;
            hold_blank_q <= hold_blank_d;
            wr_en_q      <= wr_en_d;
            wr_col_q     <= wr_col_d;
            pxl_q        <= pxl_d;
        end
    end

    // PROM download and one-cycle colour lookup
    always_ff @(posedge clk) begin
        if (prog_en) begin
            prom_mem[prog_addr] <= prog_data;
        end
        prom_dout <= prom_mem[prom_raddr_s];
    end

    // Line buffer: opaque draw writes into one half, read-and-erase on the other
    always_ff @(posedge clk) begin
        if (lbuf_we_s) begin
            lbuf[{bank_q, wr_col_q}] <= prom_dout;
        end
        if (pxl_cen) begin
            lbuf[rd_addr_s] <= 4'd0;
        end
    end

    assign busy     = busy_q;
    assign rom_cs   = rom_cs_q;
    assign rom_addr = rom_addr_q;
    assign pxl      = pxl_q;

endmodule

// File: tb/tb_jtpinpon_objline.sv
// Scoreboard bench for jtpinpon_objline: expected pixels and ROM addresses are
// queued by the stimulus and popped by an independent monitor.
module tb_jtpinpon_objline;

    localparam logic [7:0] HOFF = 8'd6;

    logic        rst, clk, pxl_cen, cen2, LHBL, hinit_x, draw, busy;
    logic        hflip, vflip, prog_en, rom_cs, rom_ok;
    logic [8:0]  hdump;
    logic [7:0]  code, xpos, prog_addr;
    logic [4:0]  pal;
    logic [3:0]  ysub, prog_data, pxl;
    logic [11:0] rom_addr;
    logic [31:0] rom_data;

    int n_cmp;
    int n_bad;

    logic [11:0] addr_q [$];
    logic [3:0]  pxl_exp_q [$];
    logic [3:0]  mdl [0:1][0:255];
    logic        bank_m;
    logic        flag_m;

    jtpinpon_objline dut (
        .rst(rst), .clk(clk), .pxl_cen(pxl_cen), .cen2(cen2), .LHBL(LHBL),
        .hinit_x(hinit_x), .hdump(hdump), .draw(draw), .busy(busy),
        .code(code), .xpos(xpos), .pal(pal), .hflip(hflip), .vflip(vflip),
        .ysub(ysub), .prog_data(prog_data), .prog_addr(prog_addr),
        .prog_en(prog_en), .rom_cs(rom_cs), .rom_addr(rom_addr),
        .rom_data(rom_data), .rom_ok(rom_ok), .pxl(pxl)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        cen2 = 1'b0;
        forever begin
            @(negedge clk);
            cen2 = ~cen2;
        end
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    task automatic timeout_fail(input string name);
        n_cmp++;
        n_bad++;
        $display("FAIL %s: timed out waiting for DUT", name);
    endtask

    // Reference colour PROM contents (pix 0 and entry 0x1F transparent)
    function automatic logic [3:0] prom_f(input logic [7:0] a);
        logic [7:0] t;
        if (a == 8'h15) return 4'hA;
        if (a == 8'h1F) return 4'h0;
        if (a[1:0] == 2'd0) return 4'h0;
        t = ((a * 8'd7) + 8'd1) % 8'd15;
        return t[3:0] + 4'd1;
    endfunction

    // Monitor: pops expectations whenever the DUT presents a pixel or a new ROM request
    initial begin : monitor
        logic       cen_s;
        logic       cs_last;
        logic [3:0] e;
        logic [11:0] ea;
        cs_last = 1'b0;
        forever begin
            @(posedge clk);
            cen_s = pxl_cen;
            #1;
            if (cen_s) begin
                if (pxl_exp_q.size() == 0) begin
                    timeout_fail("pxl_no_expectation");
                end else begin
                    e = pxl_exp_q.pop_front();
                    check("pxl", {28'd0, pxl}, {28'd0, e});
                end
            end
            if (rom_cs && !cs_last) begin
                if (addr_q.size() == 0) begin
                    timeout_fail("rom_cs_unexpected");
                end else begin
                    ea = addr_q.pop_front();
                    check("rom_addr", {20'd0, rom_addr}, {20'd0, ea});
                end
            end
            cs_last = rom_cs;
        end
    end

    task automatic sync_cen2();
        do begin
            @(negedge clk);
            #1;
        end while (cen2 !== 1'b1);
    endtask

    task automatic issue_draw(input logic [7:0] c, input logic [3:0] ys, input logic vf,
                              input logic hf, input logic [4:0] p, input logic [7:0] x);
        sync_cen2();
        code = c; ysub = ys; vflip = vf; hflip = hf; pal = p; xpos = x;
        draw = 1'b1;
        addr_q.push_back({c, vf ? ~ys : ys});
        @(posedge clk);
        #1;
        draw = 1'b0;
        check("busy_after_draw", {31'd0, busy}, 32'd1);
        check("rom_cs_after_draw", {31'd0, rom_cs}, 32'd1);
    endtask

    task automatic serve_rom(input logic [31:0] d, input int dly);
        bit done;
        done = 1'b0;
        repeat (dly) @(negedge clk);
        @(negedge clk);
        rom_data = d;
        rom_ok = 1'b1;
        for (int i = 0; i < 50; i++) begin
            @(posedge clk);
            #1;
            if (!rom_cs) begin
                done = 1'b1;
                break;
            end
        end
        if (!done) timeout_fail("rom_cs_release");
        rom_ok = 1'b0;
    endtask

    task automatic wait_idle();
        for (int i = 0; i < 40; i++) begin
            @(posedge clk);
            #1;
            if (!busy) break;
        end
        check("busy_falls", {31'd0, busy}, 32'd0);
    endtask

    task automatic model_draw(input logic [4:0] p, input logic [7:0] x, input logic hf,
                              input logic [31:0] d);
        for (int i = 0; i < 16; i++) begin
            int s;
            logic [1:0] px;
            logic [3:0] v;
            logic [7:0] col;
            s   = hf ? 15 - i : i;
            px  = {d[31 - s], d[15 - s]};
            v   = prom_f({1'b0, p, px});
            col = x + i[7:0];
            if (v != 4'd0) mdl[bank_m][col] = v;
        end
    endtask

    task automatic draw_sprite(input logic [7:0] c, input logic [3:0] ys, input logic vf,
                               input logic hf, input logic [4:0] p, input logic [7:0] x,
                               input logic [31:0] d, input int dly);
        issue_draw(c, ys, vf, hf, p, x);
        serve_rom(d, dly);
        wait_idle();
        model_draw(p, x, hf, d);
    endtask

    task automatic hinit_pulse();
        sync_cen2();
        hinit_x = 1'b1;
        @(posedge clk);
        bank_m = bank_m ^ 1'b1;
        flag_m = 1'b0;
        repeat (2) @(negedge clk);
        hinit_x = 1'b0;
    endtask

    task automatic readout(input logic lhbl);
        logic nb;
        nb = bank_m ^ 1'b1;
        for (int c = 0; c < 256; c++) begin
            logic [7:0] cc;
            cc = c[7:0];
            @(negedge clk);
            hdump = {1'b0, cc - HOFF};
            LHBL = lhbl;
            pxl_cen = 1'b1;
            pxl_exp_q.push_back((flag_m || !lhbl) ? 4'd0 : mdl[nb][cc]);
            mdl[nb][cc] = 4'd0;
        end
        @(negedge clk);
        pxl_cen = 1'b0;
        LHBL = 1'b0;
    endtask

    initial begin : stimulus
        n_cmp = 0; n_bad = 0;
        rst = 1'b1; pxl_cen = 1'b0; LHBL = 1'b0; hinit_x = 1'b0; hdump = 9'd0;
        draw = 1'b0; code = 8'd0; xpos = 8'd0; pal = 5'd0; hflip = 1'b0; vflip = 1'b0;
        ysub = 4'd0; prog_data = 4'd0; prog_addr = 8'd0; prog_en = 1'b0;
        rom_data = 32'd0; rom_ok = 1'b0;
        bank_m = 1'b0; flag_m = 1'b1;
        for (int b = 0; b < 2; b++)
            for (int c = 0; c < 256; c++) mdl[b][c] = 4'd0;

        repeat (3) @(negedge clk);
        check("reset_busy", {31'd0, busy}, 32'd0);
        check("reset_rom_cs", {31'd0, rom_cs}, 32'd0);
        check("reset_rom_addr", {20'd0, rom_addr}, 32'd0);
        check("reset_pxl", {28'd0, pxl}, 32'd0);
        rst = 1'b0;

        for (int a = 0; a < 256; a++) begin
            @(negedge clk);
            prog_addr = a[7:0];
            prog_data = prom_f(a[7:0]);
            prog_en = 1'b1;
        end
        @(negedge clk);
        prog_en = 1'b0;

        // Output forced dark before the first line start; then clear both halves
        readout(1'b1);
        hinit_pulse();
        readout(1'b0);

        // Wrapping sprite, then an overlapping one with mixed transparency
        draw_sprite(8'h12, 4'd3, 1'b0, 1'b0, 5'd5, 8'd250, 32'h0000_FFFF, 5);
        draw_sprite(8'h34, 4'd3, 1'b1, 1'b1, 5'd7, 8'd4, 32'h00A5_00C3, 0);
        hinit_pulse();
        readout(1'b1);

        // Mirrored single pixel at xpos+15
        draw_sprite(8'h56, 4'd3, 1'b1, 1'b1, 5'd5, 8'd100, 32'h8000_0000, 2);
        hinit_pulse();
        readout(1'b1);

        // Earlier line was erased when shown
        hinit_pulse();
        readout(1'b1);

        // Abort mid-draw at line start
        issue_draw(8'h78, 4'd0, 1'b0, 1'b0, 5'd5, 8'd20);
        serve_rom(32'hFFFF_FFFF, 0);
        repeat (4) @(negedge clk);
        sync_cen2();
        hinit_x = 1'b1;
        @(posedge clk);
        #1;
        check("abort_busy", {31'd0, busy}, 32'd0);
        check("abort_rom_cs", {31'd0, rom_cs}, 32'd0);
        bank_m = bank_m ^ 1'b1;
        flag_m = 1'b0;
        repeat (2) @(negedge clk);
        hinit_x = 1'b0;
        repeat (20) @(negedge clk);
        check("abort_stays_idle", {31'd0, busy}, 32'd0);
        readout(1'b0);
        hinit_pulse();
        readout(1'b1);

        // draw coinciding with line start is dropped
        sync_cen2();
        code = 8'hAA; ysub = 4'd2; vflip = 1'b0; hflip = 1'b0; pal = 5'd5; xpos = 8'd30;
        draw = 1'b1;
        hinit_x = 1'b1;
        @(posedge clk);
        #1;
        draw = 1'b0;
        check("drop_busy", {31'd0, busy}, 32'd0);
        check("drop_rom_cs", {31'd0, rom_cs}, 32'd0);
        bank_m = bank_m ^ 1'b1;
        flag_m = 1'b0;
        repeat (2) @(negedge clk);
        hinit_x = 1'b0;
        repeat (4) @(negedge clk);
        check("drop_still_idle", {31'd0, busy}, 32'd0);

        // Reset during FETCH with a drawn sprite waiting in the read half
        draw_sprite(8'h9A, 4'd7, 1'b0, 1'b0, 5'd2, 8'd40, 32'h1234_5678, 1);
        issue_draw(8'hBC, 4'd1, 1'b0, 1'b1, 5'd3, 8'd60);
        repeat (3) @(negedge clk);
        #2;
        rst = 1'b1;
        #1;
        check("rst_fetch_busy", {31'd0, busy}, 32'd0);
        check("rst_fetch_rom_cs", {31'd0, rom_cs}, 32'd0);
        check("rst_fetch_rom_addr", {20'd0, rom_addr}, 32'd0);
        check("rst_fetch_pxl", {28'd0, pxl}, 32'd0);
        bank_m = 1'b0;
        flag_m = 1'b1;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        readout(1'b1);
        hinit_pulse();
        readout(1'b1);
        draw_sprite(8'hDE, 4'd15, 1'b1, 1'b0, 5'd9, 8'd200, 32'hF0F0_3C3C, 3);
        hinit_pulse();
        readout(1'b1);

        repeat (4) @(negedge clk);
        check("pxl_queue_drained", pxl_exp_q.size(), 32'd0);
        check("addr_queue_drained", addr_q.size(), 32'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
